// File: rtl/mouse_click_ctl.sv
// Mouse left-button event decoder: turns the synchronised button level into
// single-click, double-click and long-hold events with the press-time position.
module mouse_click_ctl #(
    parameter int HOLD_CYCLES = 32_500_000,
    parameter int DBL_CYCLES  = 19_500_000,
    parameter int CNT_W       = 26
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        mouse_left_in,
    output logic        click_pulse,
    output logic        dbl_click_pulse,
    output logic        hold_out,
    output logic [11:0] click_xpos,
    output logic [11:0] click_ypos
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        WAIT2  = 2'd2,
        PRESS2 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_LIMIT = CNT_W'(DBL_CYCLES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_left_q;
    logic             w_press;

    assign w_press = mouse_left_in & ~r_left_q;

    // r_left_q resets high so a button already down at reset is not a press.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_left_q        <= 1'b1;
            click_pulse     <= 1'b0;
            dbl_click_pulse <= 1'b0;
            hold_out        <= 1'b0;
            click_xpos      <= '0;
            click_ypos      <= '0;
        end else begin
            r_left_q        <= mouse_left_in;
            click_pulse     <= 1'b0;
            dbl_click_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        click_xpos <= xpos_in;
                        click_ypos <= ypos_in;
                        r_cnt      <= '0;
                        r_state    <= PRESS;
                    end
                end
                PRESS: begin
                    if (mouse_left_in) begin
                        // Counter parks at the last value; hold stays asserted.
                        if (r_cnt == HOLD_LAST) begin
                            hold_out <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (hold_out) begin
                        hold_out <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        click_pulse <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= WAIT2;
                    end
                end
                WAIT2: begin
                    // A press on the expiry edge still counts as a double click.
                    if (w_press && (r_cnt < DBL_LIMIT)) begin
                        dbl_click_pulse <= 1'b1;
                        click_xpos      <= xpos_in;
                        click_ypos      <= ypos_in;
                        r_state         <= PRESS2;
                    end else if (r_cnt == DBL_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    if (!mouse_left_in) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
